// File: rtl/inst_sequencer_pkg.sv
// Shared definitions for the instruction sequencer, the execution core and
// their testbenches: IR field positions, opcode values and FSM encodings.
package inst_sequencer_pkg;

  localparam int unsigned SEQ_ADDR_W = 4;
  localparam int unsigned IR_W       = 32;

  // IR field positions (rsrc2 and imm overlap; imm_mode selects which is used)
  localparam int unsigned OPER_MSB     = 31;
  localparam int unsigned OPER_LSB     = 27;
  localparam int unsigned RDST_MSB     = 26;
  localparam int unsigned RDST_LSB     = 22;
  localparam int unsigned RSRC1_MSB    = 21;
  localparam int unsigned RSRC1_LSB    = 17;
  localparam int unsigned IMM_MODE_BIT = 16;
  localparam int unsigned RSRC2_MSB    = 15;
  localparam int unsigned RSRC2_LSB    = 11;
  localparam int unsigned IMM_MSB      = 15;
  localparam int unsigned IMM_LSB      = 0;

  // Opcode values understood by the core; OP_HALT is consumed by the sequencer
  localparam logic [4:0] OP_MOV  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_MUL  = 5'd3;
  localparam logic [4:0] OP_HALT = 5'b11111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_HALTED = 3'd4
  } seq_state_e;

  // Extract the opcode field of an instruction word
  function automatic logic [4:0] oper_type_of(input logic [IR_W-1:0] word);
    return word[OPER_MSB:OPER_LSB];
  endfunction

endpackage

// File: rtl/inst_sequencer.sv
// Instruction fetch/issue sequencer: fetches words from a 1-cycle synchronous
// instruction memory, hands each one to the core with an ir_valid/core_done
// handshake, advances or redirects the pc, and stops on the HALT opcode.
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W  = SEQ_ADDR_W,
  parameter logic [4:0]  HALT_OP = OP_HALT
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ir,
  output logic              ir_valid,
  input  logic              core_done,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);

  seq_state_e        state_r;
  seq_state_e        state_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_s;
  logic [31:0]       ir_r;
  logic [31:0]       ir_s;
  logic              ir_valid_r;
  logic              busy_r;
  logic              halted_r;

  // State register
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, next-pc and next-ir decode
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    ir_s    = ir_r;
    case (state_r)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_s = ST_FETCH;
          pc_s    = '0;
        end else begin
          state_s = state_r;
        end
      end
      ST_FETCH: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        // a HALT word is never presented to the core; ir keeps the last instruction
        if (oper_type_of(imem_rdata) == HALT_OP) begin
          state_s = ST_HALTED;
        end else begin
          ir_s    = imem_rdata;
          state_s = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (core_done) begin
          state_s = ST_FETCH;
          pc_s    = jmp_en ? jmp_addr : (pc_r + PC_STEP);
        end else begin
          state_s = ST_ISSUE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        pc_s    = '0;
        ir_s    = '0;
      end
    endcase
  end

  // Registered datapath and status outputs, derived from the next state so they line up with it
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pc_r       <= '0;
      ir_r       <= 32'd0;
      ir_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      pc_r       <= pc_s;
      ir_r       <= ir_s;
      ir_valid_r <= (state_s == ST_ISSUE);
      busy_r     <= (state_s == ST_FETCH) || (state_s == ST_WAIT) || (state_s == ST_ISSUE);
      halted_r   <= (state_s == ST_HALTED);
    end
  end

  // Memory reads are side-effect free, so the address simply follows pc
  assign imem_addr = pc_r;
  assign pc        = pc_r;
  assign ir        = ir_r;
  assign ir_valid  = ir_valid_r;
  assign busy      = busy_r;
  assign halted    = halted_r;

endmodule

// File: doc/inst_sequencer.md
# inst_sequencer

Instruction fetch/issue sequencer that takes over the job of driving the execution core's instruction register (IR). It reads 32-bit instruction words from a synchronous instruction memory, presents each word to the core with a valid/done handshake, and advances a program counter, honouring jumps and a HALT opcode. It sits between the instruction memory and the `top` execution core (GPR file, SGPR, ALU).

## Interface
- ADDR_W, 4, program counter / instruction memory address width (2^ADDR_W words)
- HALT_OP, 5'b11111, oper_type value that stops the sequencer
- clk  input  1  system clock; all state updates on rising edge
- sys_rst_n  input  1  reset; asynchronous, active-low
- start  input  1  begin execution from address 0 (honoured only in IDLE or HALTED)
- imem_addr  output  ADDR_W  instruction memory read address
- imem_rdata  input  32  instruction word, valid one cycle after imem_addr
- ir  output  32  instruction presented to core (oper_type [31:27], rdst [26:22], rsrc1 [21:17], imm_mode [16], rsrc2 [15:11], imm [15:0])
- ir_valid  output  1  ir holds an instruction the core must execute
- core_done  input  1  one-cycle pulse from core: current instruction retired
- jmp_en  input  1  sampled with core_done: take jump
- jmp_addr  input  ADDR_W  jump target, sampled with core_done
- pc  output  ADDR_W  address of current/next instruction
- busy  output  1  high in FETCH, WAIT, ISSUE
- halted  output  1  high in HALTED

## Operation
- States: IDLE, FETCH, WAIT, ISSUE, HALTED.
- IDLE: outputs quiescent; start=1 -> pc<=0, go FETCH.
- FETCH: imem_addr=pc; go WAIT unconditionally.
- WAIT: imem_rdata valid; if imem_rdata[31:27]==HALT_OP -> go HALTED, ir unchanged, ir_valid stays 0; else ir<=imem_rdata, go ISSUE.
- ISSUE: ir_valid=1 and ir stable until core_done. On core_done: pc<=jmp_en ? jmp_addr : pc+1, go FETCH.
- pc+1 wraps modulo 2^ADDR_W (max address -> 0); no error raised.
- HALTED: pc holds address of HALT word; start=1 -> pc<=0, go FETCH.
- core_done outside ISSUE: ignored (no pc change). jmp_en without core_done: ignored.
- start outside IDLE/HALTED: ignored.
- imem_addr driven with pc in every state (memory read has no side effects).
- Reset (any time, including mid-ISSUE): state IDLE, pc=0, ir=0, ir_valid=0, busy=0, halted=0; pending instruction discarded.

## Timing
- start at cycle t (IDLE) -> FETCH t+1, WAIT t+2, ISSUE from t+3 (ir_valid=1 at t+3).
- core_done at cycle t (in ISSUE) -> ir_valid=0 at t+1, pc updated at t+1, next ir_valid=1 at t+3.
- Minimum instruction period: 3 cycles (core_done in first ISSUE cycle).
- HALT word fetched: halted=1 and busy=0 from the cycle after WAIT; ir_valid never asserted for it.
- All outputs registered except imem_addr (combinational from pc, registered pc).
- core_done may be asserted in the same cycle ir_valid first rises; it is accepted.

## Structure
- Shared defines include (used by core and testbenches): IR field positions (oper_type, rdst, rsrc1, imm_mode, rsrc2, imm), opcode values including HALT_OP, state encodings.
- Single module; no sub-module needed. Instruction memory and core are external; a bench-level behavioural imem model (1-cycle read latency) is provided with the testbench.

## Test plan
- Reset then start; imem[0..2]={ADD r2,r0,r1 ; MUL r2,r0,r1 ; HALT}; core_done 1 cycle after each ir_valid -> ir==imem[0] at t+3, then imem[1], then halted=1, pc=2, ir_valid never high for HALT.
- Core model delays core_done 5 cycles -> ir and ir_valid stable for all 5 cycles; pc unchanged until cycle after done.
- core_done with jmp_en=1, jmp_addr=7 while at pc=1 -> next fetched address 7, ir==imem[7].
- ADDR_W=4, no HALT in imem[14..15], imem[0]=HALT after restart path: pc runs 14,15,0 -> wraps to 0 and halts with pc=0.
- Assert sys_rst_n=0 mid-ISSUE (asynchronously, between edges) -> ir_valid, ir, pc, busy clear immediately; after release, start re-runs from address 0.
- Spurious core_done in IDLE/HALTED and start during ISSUE -> no pc change, no state change.
